// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one DRAM bridge port between NREQ requesters.
// One whole transaction per grant: IDLE -> BUSY (enables held) -> RESP (done).
module dram_port_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_read,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_done,
  output logic [DATA_W-1:0]      req_rdata,
  output logic [ADDR_W-1:0]      dramAddress,
  output logic [DATA_W-1:0]      dramWriteData,
  output logic                   readEnable,
  output logic                   writeEnable,
  input  logic [DATA_W-1:0]      dramReadData,
  input  logic                   dramValid,
  output logic                   busy,
  output logic [1:0]             owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [1:0]        rr_ptr_q;
  logic [1:0]        owner_q;
  logic              op_wr_q;
  logic [3:0]        done_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_en_q;
  logic              wr_en_q;

  logic [3:0]        req_ext;
  logic [3:0]        wr_ext;
  logic              any_req;
  logic [1:0]        gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic [1:0]        rr_ptr_d;

  // Scan from rr_ptr upward, wrapping at NREQ; first hit wins.
  always_comb begin
    req_ext = '0;
    wr_ext  = '0;
    req_ext[NREQ-1:0] = req_read | req_write;
    wr_ext[NREQ-1:0]  = req_write;
    any_req = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      logic [1:0] cand;
      cand = 2'((int'(rr_ptr_q) + k) % NREQ);
      if (!any_req && req_ext[cand]) begin
        any_req = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    gnt_wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
  end

  assign rr_ptr_d = (owner_q == 2'(NREQ-1)) ? 2'd0 : owner_q + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_wr_q  <= 1'b0;
      done_q   <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= gnt_idx;
            op_wr_q <= wr_ext[gnt_idx];
            addr_q  <= gnt_addr;
            wdata_q <= gnt_wdata;
            rd_en_q <= ~wr_ext[gnt_idx];
            wr_en_q <= wr_ext[gnt_idx];
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (dramValid) begin
            if (!op_wr_q) rdata_q <= dramReadData;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 4'b0001 << owner_q;
            state_q <= RESP;
          end
        end
        RESP: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_done      = done_q[NREQ-1:0];
  assign req_rdata     = rdata_q;
  assign dramAddress   = addr_q;
  assign dramWriteData = wdata_q;
  assign readEnable    = rd_en_q;
  assign writeEnable   = wr_en_q;
  assign busy          = (state_q != IDLE);
  assign owner         = owner_q;

endmodule
